vpu_alu_sequencer: RTL and testbench



---
 rtl/vpu_alu_sequencer_if.sv | 60 ++++++
 rtl/vpu_alu_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_vpu_alu_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vpu_alu_sequencer_if.sv
// ----------------------------------------------------------------------------
// vpu_alu_sequencer_if
//   Command, operand and result handshakes of the VPU ALU sequencer.
//
//   Signals (sequencer view):
//     req_valid_i / req_ready_o      command handshake
//     req_alu_sel_i                  target ALU index
//     req_delay_i                    delay loaded into the ALU timing counter
//     req_three_op_i                 1 = op_2 is a real operand
//     src_valid_i / src_ready_o      operand bundle handshake
//     src_op_0_i .. src_op_2_i       operands
//     dst_valid_o / dst_ready_i      result handshake
//     dst_data_o                     result
//
//   Handshake rule for all three channels: a transfer happens on the rising
//   clock edge where valid and ready are both high. Valid, once raised, keeps
//   its payload stable until that edge. Ready never depends on valid.
//
//   Modports: slave = the sequencer, master = the side driving commands and
//   consuming results.
// ----------------------------------------------------------------------------
interface vpu_alu_sequencer_if #(
  parameter int OPCODE_WIDTH  = 32,
  parameter int MAX_DELAY_LG2 = 2,
  parameter int ALU_SEL_WIDTH = 2
);
  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [ALU_SEL_WIDTH-1:0] req_alu_sel_i;
  logic [MAX_DELAY_LG2-1:0] req_delay_i;
  logic                     req_three_op_i;

  logic                     src_valid_i;
  logic                     src_ready_o;
  logic [OPCODE_WIDTH-1:0]  src_op_0_i;
  logic [OPCODE_WIDTH-1:0]  src_op_1_i;
  logic [OPCODE_WIDTH-1:0]  src_op_2_i;

  logic                     dst_valid_o;
  logic                     dst_ready_i;
  logic [OPCODE_WIDTH-1:0]  dst_data_o;

  modport slave (
    input  req_valid_i, req_alu_sel_i, req_delay_i, req_three_op_i,
    output req_ready_o,
    input  src_valid_i, src_op_0_i, src_op_1_i, src_op_2_i,
    output src_ready_o,
    output dst_valid_o, dst_data_o,
    input  dst_ready_i
  );

  modport master (
    output req_valid_i, req_alu_sel_i, req_delay_i, req_three_op_i,
    input  req_ready_o,
    output src_valid_i, src_op_0_i, src_op_1_i, src_op_2_i,
    input  src_ready_o,
    input  dst_valid_o, dst_data_o,
    output dst_ready_i
  );
endinterface

// File: rtl/vpu_alu_sequencer.sv
// ----------------------------------------------------------------------------
// vpu_alu_sequencer
//   Runs one VPU ALU operation at a time on a bank of ALU_CNT fixed-latency
//   units: accept a command, accept the operand bundle, register and hold the
//   operands, pulse start to the selected unit, wait for its done, capture its
//   result and offer it on the result channel.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     bus               command / operand / result handshakes (slave side)
//     alu_op_0_o..2_o   registered operands broadcast to every unit
//     alu_op_valid_o    operand valid mask (3'b011 two-operand, 3'b111 three)
//     alu_delay_o       registered delay for the unit timing counter
//     alu_start_o       one-hot, one-cycle start pulse
//     alu_result_i      packed unit results, unit k at [k*W +: W]
//     alu_done_i        per-unit done
//     busy_o            high whenever an operation is in progress
//     dbg_state_o       current FSM state encoding
//
//   Optional feature, macro VPU_ALU_SEQ_PERF_CNT_EN:
//     perf_clr_i        synchronous clear of both counters (wins over increment)
//     perf_op_cnt_o     completed result handshakes, wraps at 2^32
//     perf_stall_cnt_o  result cycles held off by dst_ready_i=0, wraps at 2^32
// ----------------------------------------------------------------------------
module vpu_alu_sequencer #(
  parameter int OPCODE_WIDTH    = 32,
  parameter int SRAM_R_PORT_CNT = 3,
  parameter int MAX_DELAY_LG2   = 2,
  parameter int ALU_CNT         = 4,
  parameter int ALU_SEL_WIDTH   = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  vpu_alu_sequencer_if.slave               bus,
  output logic [OPCODE_WIDTH-1:0]          alu_op_0_o,
  output logic [OPCODE_WIDTH-1:0]          alu_op_1_o,
  output logic [OPCODE_WIDTH-1:0]          alu_op_2_o,
  output logic [SRAM_R_PORT_CNT-1:0]       alu_op_valid_o,
  output logic [MAX_DELAY_LG2-1:0]         alu_delay_o,
  output logic [ALU_CNT-1:0]               alu_start_o,
  input  logic [ALU_CNT*OPCODE_WIDTH-1:0]  alu_result_i,
  input  logic [ALU_CNT-1:0]               alu_done_i,
  output logic                             busy_o,
  output logic [2:0]                       dbg_state_o
`ifdef VPU_ALU_SEQ_PERF_CNT_EN
  ,
  input  logic                             perf_clr_i,
  output logic [31:0]                      perf_op_cnt_o,
  output logic [31:0]                      perf_stall_cnt_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [ALU_SEL_WIDTH-1:0]   sel_q;
  logic                       three_op_q;
  logic [MAX_DELAY_LG2-1:0]   delay_q;
  logic [OPCODE_WIDTH-1:0]    op_0_q, op_1_q, op_2_q;
  logic [SRAM_R_PORT_CNT-1:0] op_valid_q, op_valid_nxt;
  logic [OPCODE_WIDTH-1:0]    result_q, sel_result;

  logic req_fire, src_fire, done_hit, dst_fire;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.req_ready_o = 1'b0;
    bus.src_ready_o = 1'b0;
    bus.dst_valid_o = 1'b0;
    alu_start_o     = '0;
    req_fire        = 1'b0;
    src_fire        = 1'b0;
    done_hit        = 1'b0;
    dst_fire        = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.req_ready_o = 1'b1;
        req_fire        = bus.req_valid_i;
        if (req_fire) state_d = S_LOAD;
      end
      S_LOAD: begin
        bus.src_ready_o = 1'b1;
        src_fire        = bus.src_valid_i;
        if (src_fire) state_d = S_START;
      end
      S_START: begin
        // done is deliberately not looked at here: the selected unit may
        // still be showing done from the previous operation.
        alu_start_o[sel_q] = 1'b1;
        state_d            = S_EXEC;
      end
      S_EXEC: begin
        done_hit = alu_done_i[sel_q];
        if (done_hit) state_d = S_WB;
      end
      S_WB: begin
        bus.dst_valid_o = 1'b1;
        dst_fire        = bus.dst_ready_i;
        if (dst_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    op_valid_nxt                    = '1;
    op_valid_nxt[SRAM_R_PORT_CNT-1] = three_op_q;
  end

  always_comb sel_result = alu_result_i[int'(sel_q)*OPCODE_WIDTH +: OPCODE_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      three_op_q <= 1'b0;
      delay_q    <= '0;
      op_0_q     <= '0;
      op_1_q     <= '0;
      op_2_q     <= '0;
      op_valid_q <= '0;
      result_q   <= '0;
    end else begin
      if (req_fire) begin
        sel_q      <= bus.req_alu_sel_i;
        three_op_q <= bus.req_three_op_i;
        delay_q    <= bus.req_delay_i;
      end
      // Operands stay frozen for the whole op so every unit sees stable inputs.
      if (src_fire) begin
        op_0_q     <= bus.src_op_0_i;
        op_1_q     <= bus.src_op_1_i;
        op_2_q     <= three_op_q ? bus.src_op_2_i : '0;
        op_valid_q <= op_valid_nxt;
      end else if (dst_fire) begin
        op_0_q     <= '0;
        op_1_q     <= '0;
        op_2_q     <= '0;
        op_valid_q <= '0;
      end
      if (done_hit) result_q <= sel_result;
    end
  end

  assign alu_op_0_o     = op_0_q;
  assign alu_op_1_o     = op_1_q;
  assign alu_op_2_o     = op_2_q;
  assign alu_op_valid_o = op_valid_q;
  assign alu_delay_o    = delay_q;
  assign bus.dst_data_o = result_q;
  assign busy_o         = (state_q != S_IDLE);
  assign dbg_state_o    = state_q;

`ifdef VPU_ALU_SEQ_PERF_CNT_EN
  // ---------------------------------------------------------------- perf
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_op_cnt_o    <= '0;
      perf_stall_cnt_o <= '0;
    end else if (perf_clr_i) begin
      perf_op_cnt_o    <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (dst_fire) perf_op_cnt_o <= perf_op_cnt_o + 32'd1;
      if (state_q == S_WB && !bus.dst_ready_i)
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vpu_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_vpu_alu_sequencer
//   Self-checking bench for vpu_alu_sequencer. An ALU bank model answers start
//   pulses with done after delay+1 cycles; expected results come from the
//   per-unit function applied to the operands the bench itself sent.
//   Unit functions: 0 = max(op0,op1), 1 = min of valid ops,
//   2 = max of valid ops, 3 = sum of valid ops.
// ----------------------------------------------------------------------------
module tb_vpu_alu_sequencer;
  localparam int W  = 32;
  localparam int P  = 3;
  localparam int DL = 2;
  localparam int N  = 4;
  localparam int SW = 2;

  // ---------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vpu_alu_sequencer_if #(.OPCODE_WIDTH(W), .MAX_DELAY_LG2(DL), .ALU_SEL_WIDTH(SW)) bus ();

  logic [W-1:0]   alu_op_0, alu_op_1, alu_op_2;
  logic [P-1:0]   alu_op_valid;
  logic [DL-1:0]  alu_delay;
  logic [N-1:0]   alu_start;
  logic [N*W-1:0] alu_result;
  logic [N-1:0]   alu_done;
  logic           busy;
  logic [2:0]     dbg_state;
`ifdef VPU_ALU_SEQ_PERF_CNT_EN
  logic           perf_clr;
  logic [31:0]    perf_op_cnt, perf_stall_cnt;
`endif

  vpu_alu_sequencer #(
    .OPCODE_WIDTH(W), .SRAM_R_PORT_CNT(P), .MAX_DELAY_LG2(DL),
    .ALU_CNT(N), .ALU_SEL_WIDTH(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_op_0_o(alu_op_0), .alu_op_1_o(alu_op_1), .alu_op_2_o(alu_op_2),
    .alu_op_valid_o(alu_op_valid), .alu_delay_o(alu_delay),
    .alu_start_o(alu_start), .alu_result_i(alu_result), .alu_done_i(alu_done),
    .busy_o(busy), .dbg_state_o(dbg_state)
`ifdef VPU_ALU_SEQ_PERF_CNT_EN
    , .perf_clr_i(perf_clr), .perf_op_cnt_o(perf_op_cnt), .perf_stall_cnt_o(perf_stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] alu_fn(input int k, input logic [W-1:0] a, b, c, input bit three);
    logic [W-1:0] r;
    case (k)
      0: r = (a > b) ? a : b;
      1: begin r = (a < b) ? a : b; if (three && c < r) r = c; end
      2: begin r = (a > b) ? a : b; if (three && c > r) r = c; end
      default: r = a + b + (three ? c : '0);
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------- ALU bank model
  bit          model_en = 1'b1;
  logic [N-1:0] extra_done = '0;
  logic        pend;
  logic [DL-1:0] cnt;
  int          unit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0; cnt <= '0; unit <= 0;
    end else if (alu_start != '0) begin
      pend <= model_en;
      cnt  <= alu_delay;
      for (int k = 0; k < N; k++) if (alu_start[k]) unit <= k;
    end else if (pend) begin
      if (cnt == '0) pend <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  always_comb begin
    alu_done = extra_done;
    if (pend && cnt == '0) alu_done[unit] = 1'b1;
    alu_result = '0;
    for (int k = 0; k < N; k++)
      alu_result[k*W +: W] = alu_fn(k, alu_op_0, alu_op_1, alu_op_2, alu_op_valid[2]);
  end

  // ---------------------------------------------------------- driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.req_valid_i = 1'b0; bus.req_alu_sel_i = '0; bus.req_delay_i = '0;
    bus.req_three_op_i = 1'b0; bus.src_valid_i = 1'b0;
    bus.src_op_0_i = '0; bus.src_op_1_i = '0; bus.src_op_2_i = '0;
    bus.dst_ready_i = 1'b1;
`ifdef VPU_ALU_SEQ_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
  endtask

  // mode 0: ALU model answers; 1: wrong-unit done then right done;
  // 2: stale done during START then right done.
  task automatic run_op(input logic [1:0] sel, input logic [1:0] d, input bit three,
                        input logic [W-1:0] a, b, c, input int stall, input int mode,
                        input bit early_src);
    logic [W-1:0] exp;
    logic [N-1:0] exp_start;
    logic [P-1:0] exp_valid;
    logic [31:0]  st0, op0;
    int cyc, guard;
    exp_q.push_back(alu_fn(int'(sel), a, b, c, three));
    exp_start = '0; exp_start[sel] = 1'b1;
    exp_valid = three ? 3'b111 : 3'b011;
    model_en = (mode == 0);
    st0 = 0; op0 = 0;
    guard = 0;
    while (bus.req_ready_o !== 1'b1 && guard < 20) begin tick(); guard++; end
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL req_ready_wait: got %b need 1", bus.req_ready_o); end
    bus.req_valid_i = 1'b1; bus.req_alu_sel_i = sel; bus.req_delay_i = d; bus.req_three_op_i = three;
    if (early_src) begin
      bus.src_valid_i = 1'b1; bus.src_op_0_i = ~a; bus.src_op_1_i = ~b; bus.src_op_2_i = ~c;
      checks++; if (bus.src_ready_o !== 1'b0) begin errors++; $display("FAIL src_ready_idle: got %b need 0", bus.src_ready_o); end
    end
    tick(); cyc = 1;
    bus.req_valid_i = 1'b0;
    checks++; if (bus.src_ready_o !== 1'b1) begin errors++; $display("FAIL src_ready_load: got %b need 1", bus.src_ready_o); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_load: got %b need 1", busy); end
    bus.src_valid_i = 1'b1; bus.src_op_0_i = a; bus.src_op_1_i = b; bus.src_op_2_i = c;
    tick(); cyc = 2;
    bus.src_valid_i = 1'b0;
    checks++; if (alu_start !== exp_start) begin errors++; $display("FAIL start_onehot: got %b need %b", alu_start, exp_start); end
    checks++; if (alu_op_valid !== exp_valid) begin errors++; $display("FAIL op_valid: got %b need %b", alu_op_valid, exp_valid); end
    checks++; if (alu_op_0 !== a || alu_op_1 !== b) begin errors++; $display("FAIL op01: got %h/%h need %h/%h", alu_op_0, alu_op_1, a, b); end
    checks++; if (alu_op_2 !== (three ? c : '0)) begin errors++; $display("FAIL op2: got %h need %h", alu_op_2, three ? c : '0); end
    checks++; if (alu_delay !== d) begin errors++; $display("FAIL delay: got %0d need %0d", alu_delay, d); end
    if (mode == 2) extra_done = exp_start;
    tick(); cyc = 3;
    extra_done = '0;
    checks++; if (alu_start !== '0) begin errors++; $display("FAIL start_one_cycle: got %b need 0", alu_start); end
    if (mode == 1) begin
      extra_done = ~exp_start;
      tick(); cyc++;
      extra_done = '0;
    end
    if (mode != 0) begin
      checks++; if (bus.dst_valid_o !== 1'b0) begin errors++; $display("FAIL ignored_done_a: got %b need 0", bus.dst_valid_o); end
      tick(); cyc++;
      checks++; if (bus.dst_valid_o !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ignored_done_b: valid %b busy %b need 0/1", bus.dst_valid_o, busy); end
      extra_done = exp_start;
      tick(); cyc++;
      extra_done = '0;
    end
    guard = 0;
    while (bus.dst_valid_o !== 1'b1 && guard < 40) begin tick(); cyc++; guard++; end
    checks++; if (bus.dst_valid_o !== 1'b1) begin errors++; $display("FAIL dst_valid_timeout: got %b need 1", bus.dst_valid_o); end
    if (mode == 0) begin
      checks++; if (cyc != 4 + int'(d)) begin errors++; $display("FAIL latency: got %0d need %0d", cyc, 4 + int'(d)); end
    end
    exp = exp_q.pop_front();
    checks++; if (bus.dst_data_o !== exp) begin errors++; $display("FAIL dst_data: got %h need %h", bus.dst_data_o, exp); end
`ifdef VPU_ALU_SEQ_PERF_CNT_EN
    st0 = perf_stall_cnt; op0 = perf_op_cnt;
`endif
    for (int i = 0; i < stall; i++) begin
      bus.dst_ready_i = 1'b0;
      tick();
      checks++; if (bus.dst_valid_o !== 1'b1 || bus.dst_data_o !== exp) begin errors++; $display("FAIL stall_hold: valid %b data %h need 1/%h", bus.dst_valid_o, bus.dst_data_o, exp); end
      checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL stall_req_ready: got %b need 0", bus.req_ready_o); end
    end
    bus.dst_ready_i = 1'b1;
    tick();
    checks++; if (bus.dst_valid_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wb_one_cycle: valid %b busy %b need 0/0", bus.dst_valid_o, busy); end
    checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL req_ready_after: got %b need 1", bus.req_ready_o); end
    checks++; if (alu_op_valid !== '0 || alu_op_0 !== '0) begin errors++; $display("FAIL op_clear: valid %b op0 %h need 0/0", alu_op_valid, alu_op_0); end
`ifdef VPU_ALU_SEQ_PERF_CNT_EN
    checks++; if (perf_stall_cnt - st0 !== 32'(stall)) begin errors++; $display("FAIL perf_stall: got %0d need %0d", perf_stall_cnt - st0, stall); end
    checks++; if (perf_op_cnt - op0 !== 32'd1) begin errors++; $display("FAIL perf_op: got %0d need 1", perf_op_cnt - op0); end
`endif
  endtask

  // ---------------------------------------------------------- scenarios
  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (bus.req_ready_o !== 1'b1 || bus.src_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: req %b src %b need 1/0", bus.req_ready_o, bus.src_ready_o); end
    checks++; if (bus.dst_valid_o !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: %b/%b need 0/0", bus.dst_valid_o, busy); end
    checks++; if (alu_start !== '0 || alu_op_valid !== '0) begin errors++; $display("FAIL reset_alu_ctl: start %b valid %b need 0/0", alu_start, alu_op_valid); end
    checks++; if (alu_op_0 !== '0 || alu_op_1 !== '0 || alu_op_2 !== '0 || alu_delay !== '0 || bus.dst_data_o !== '0) begin errors++; $display("FAIL reset_regs: nonzero register after reset, data %h", bus.dst_data_o); end
  endtask

  task automatic test_imax();
    run_op(2'd0, 2'd2, 1'b0, 32'd5, 32'd9, 32'd0, 0, 0, 1'b0);
  endtask

  task automatic test_three_op();
    run_op(2'd2, 2'd1, 1'b1, 32'd7, 32'd3, 32'd12, 0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_exec();
    model_en = 1'b1;
    bus.req_valid_i = 1'b1; bus.req_alu_sel_i = 2'd1; bus.req_delay_i = 2'd3; bus.req_three_op_i = 1'b0;
    tick();
    bus.req_valid_i = 1'b0;
    bus.src_valid_i = 1'b1; bus.src_op_0_i = 32'd40; bus.src_op_1_i = 32'd30;
    tick();
    bus.src_valid_i = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || bus.dst_valid_o !== 1'b0 || alu_start !== '0) begin errors++; $display("FAIL rst_exec_ctl: busy %b valid %b start %b need 0", busy, bus.dst_valid_o, alu_start); end
    checks++; if (alu_op_valid !== '0 || alu_op_0 !== '0 || alu_op_1 !== '0 || alu_delay !== '0 || bus.dst_data_o !== '0) begin errors++; $display("FAIL rst_exec_regs: op0 %h delay %0d data %h need 0", alu_op_0, alu_delay, bus.dst_data_o); end
    tick();
    rst_n = 1'b1;
    tick();
    run_op(2'd1, 2'd3, 1'b0, 32'd40, 32'd30, 32'd0, 0, 0, 1'b0);
  endtask

  task automatic test_wrong_unit();
    run_op(2'd3, 2'd0, 1'b1, 32'd100, 32'd20, 32'd3, 0, 1, 1'b0);
  endtask

  task automatic test_stale_done();
    run_op(2'd1, 2'd2, 1'b1, 32'd8, 32'd6, 32'd7, 0, 2, 1'b0);
  endtask

  task automatic test_backpressure();
    run_op(2'd3, 2'd1, 1'b0, 32'h1234, 32'h0FF0, 32'd0, 5, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(2'd0, 2'd0, 1'b0, 32'd1, 32'd2, 32'd3, 0, 0, 1'b1);
    run_op(2'd2, 2'd3, 1'b1, 32'd11, 32'd22, 32'd5, 0, 0, 1'b0);
  endtask

`ifdef VPU_ALU_SEQ_PERF_CNT_EN
  task automatic test_perf_clear();
    perf_clr = 1'b1;
    tick();
    perf_clr = 1'b0;
    checks++; if (perf_op_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_clear: op %0d stall %0d need 0/0", perf_op_cnt, perf_stall_cnt); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, $urandom_range(0, 3), 0, 1'($urandom_range(0, 1)));
  endtask

  // ---------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_imax();
    test_three_op();
    test_reset_mid_exec();
    test_wrong_unit();
    test_stale_done();
    test_backpressure();
    test_back_to_back();
`ifdef VPU_ALU_SEQ_PERF_CNT_EN
    test_perf_clear();
`endif
    test_random();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: %0d entries need 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
